// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter: shares the main-CPU work RAM port between the Z80 and the hiscore engine
//   clk_sys, reset (async, active-high)
//   cpu_addr/cpu_din/cpu_cs/cpu_we -> cpu_dout : CPU side of the RAM port
//   hs_address/hs_data_in/hs_write/hs_intent_read/hs_intent_write -> hs_data_out : hiscore side
//   hs_pause -> pause module, paused <- pause module acknowledge
//   hs_grant : hiscore currently owns the RAM port
//   ram_addr/ram_din/ram_we -> work RAM, ram_dout <- work RAM
module hs_ram_arbiter #(
   parameter int AW    = 16,
   parameter int DW    = 8,
   parameter int GUARD = 2
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_din,
   input  logic          cpu_cs,
   input  logic          cpu_we,
   output logic [DW-1:0] cpu_dout,
   input  logic [AW-1:0] hs_address,
   input  logic [DW-1:0] hs_data_in,
   input  logic          hs_write,
   input  logic          hs_intent_read,
   input  logic          hs_intent_write,
   output logic [DW-1:0] hs_data_out,
   output logic          hs_pause,
   input  logic          paused,
   output logic          hs_grant,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   output logic          ram_we,
   input  logic [DW-1:0] ram_dout
);
   localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
   localparam logic [GW-1:0] G_LOAD = GW'(GUARD);
   localparam logic [GW-1:0] G_ONE  = GW'(1);
   localparam logic [2:0] S_CPU  = 3'd0;
   localparam logic [2:0] S_PREQ = 3'd1;
   localparam logic [2:0] S_GIN  = 3'd2;
   localparam logic [2:0] S_HS   = 3'd3;
   localparam logic [2:0] S_GOUT = 3'd4;
   // with no guard the gap states are skipped entirely
   localparam logic [2:0] S_IN  = (GUARD == 0) ? S_HS  : S_GIN;
   localparam logic [2:0] S_OUT = (GUARD == 0) ? S_CPU : S_GOUT;
   logic          intent;
   logic [2:0]    state, state_nx;
   logic [GW-1:0] gcnt, gcnt_nx;
   assign intent = hs_intent_read | hs_intent_write;
   always_comb begin
      state_nx = state;
      gcnt_nx  = gcnt;
      case (state)
         S_CPU:  state_nx = intent ? S_PREQ : S_CPU;
         S_PREQ: begin
            if (!intent) state_nx = S_CPU;
            else if (paused) begin
               state_nx = S_IN;
               gcnt_nx  = G_LOAD;
            end
         end
         S_GIN: begin
            if (!paused) begin
               state_nx = S_PREQ;
               gcnt_nx  = '0;
            end else begin
               gcnt_nx  = gcnt - G_ONE;
               state_nx = (gcnt == G_ONE) ? S_HS : S_GIN;
            end
         end
         S_HS: begin
            if (!intent) begin
               state_nx = S_OUT;
               gcnt_nx  = G_LOAD;
            end else if (!paused) state_nx = S_PREQ;
         end
         S_GOUT: begin
            gcnt_nx  = gcnt - G_ONE;
            state_nx = (gcnt == G_ONE) ? S_CPU : S_GOUT;
         end
         default: begin
            state_nx = S_CPU;
            gcnt_nx  = '0;
         end
      endcase
   end
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state       <= S_CPU;
         gcnt        <= '0;
         hs_pause    <= 1'b0;
         hs_grant    <= 1'b0;
         hs_data_out <= '0;
      end else begin
         state       <= state_nx;
         gcnt        <= gcnt_nx;
         hs_pause    <= state_nx != S_CPU;
         hs_grant    <= state_nx == S_HS;
         hs_data_out <= hs_grant ? ram_dout : hs_data_out;
      end
   end
   assign ram_addr = hs_grant ? hs_address : cpu_addr;
   assign ram_din  = hs_grant ? hs_data_in : cpu_din;
   // a hiscore write in the cycle the pause drops out is suppressed, since the CPU may already be running
   assign ram_we   = hs_grant ? hs_write & paused : (state == S_CPU) & cpu_cs & cpu_we & ~paused;
   assign cpu_dout = ram_dout;
endmodule
